// File: rtl/pair_adder_ctrl_pkg.sv
// Shared widths and FSM encoding for the pair adder controller.
package pair_adder_ctrl_pkg;

  localparam int unsigned OpW  = 5;
  localparam int unsigned SumW = 6;

  typedef enum logic [0:0] {
    StEmpty = 1'b0,
    StHoldA = 1'b1
  } state_e;

endpackage

// File: rtl/adder5.sv
// 5-bit unsigned ripple-carry adder; the carry out becomes sum bit 5.
module adder5
  import pair_adder_ctrl_pkg::*;
(
  input  logic [OpW-1:0]  a_i,
  input  logic [OpW-1:0]  b_i,
  output logic [SumW-1:0] sum_o
);

  logic [OpW:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < OpW; i++) begin : g_fa
    assign sum_o[i]   = a_i[i] ^ b_i[i] ^ carry[i];
    assign carry[i+1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
  end

  assign sum_o[SumW-1] = carry[OpW];

endmodule

// File: rtl/sum_fifo2.sv
// Two-entry synchronous queue for sums; head reads as zero when empty.
module sum_fifo2
  import pair_adder_ctrl_pkg::*;
#(
  parameter int unsigned Width = SumW
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             pop_i,
  output logic [Width-1:0] head_o,
  output logic [1:0]       count_o
);

  logic [Width-1:0] mem_q [2];
  logic             rd_ptr_q;
  logic [1:0]       count_q, count_d;
  logic             wr_ptr;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && (count_q != 2'd0);
  // A push into a full queue is only legal when the head leaves in the same cycle.
  assign do_push = push_i && ((count_q != 2'd2) || do_pop);
  assign wr_ptr  = rd_ptr_q ^ count_q[0];

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr] <= push_data_i;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  assign head_o  = (count_q != 2'd0) ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/pair_adder_ctrl.sv
// Pairs consecutive stream operands, sums them with adder5 and buffers results
// in a two-entry output queue.
module pair_adder_ctrl
  import pair_adder_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OpW-1:0]   in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [SumW-1:0]  out_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] pair_count,
  output logic             busy
);

  localparam logic [1:0] FullCnt = 2'(DEPTH);

  state_e           state_q;
  logic [OpW-1:0]   a_q;
  logic [CNT_W-1:0] pair_count_q;
  logic [1:0]       count;
  logic             in_hs, pair_push, flush_act, push, pop;
  logic [OpW-1:0]   b_op;
  logic [SumW-1:0]  sum;

  assign in_ready  = (state_q == StEmpty) || (count != FullCnt);
  assign in_hs     = in_valid && in_ready;
  assign pair_push = in_hs && (state_q == StHoldA);
  // An input handshake always wins over a simultaneous flush.
  assign flush_act = flush && (state_q == StHoldA) && (count != FullCnt) && !in_hs;
  assign push      = pair_push || flush_act;
  assign b_op      = pair_push ? in_data : '0;

  adder5 u_adder5 (
    .a_i   (a_q),
    .b_i   (b_op),
    .sum_o (sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StEmpty;
      a_q          <= '0;
      pair_count_q <= '0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (in_hs) begin
            a_q     <= in_data;
            state_q <= StHoldA;
          end
        end
        StHoldA: begin
          if (push) begin
            state_q <= StEmpty;
          end
        end
        default: state_q <= StEmpty;
      endcase
      if (push) begin
        pair_count_q <= pair_count_q + 1'b1;
      end
    end
  end

  assign pop = out_valid && out_ready;

  sum_fifo2 #(
    .Width (SumW)
  ) u_sum_fifo2 (
    .clk_i       (clk),
    .rst_i       (rst),
    .push_i      (push),
    .push_data_i (sum),
    .pop_i       (pop),
    .head_o      (out_sum),
    .count_o     (count)
  );

  assign out_valid  = (count != 2'd0);
  assign busy       = (state_q == StHoldA) || (count != 2'd0);
  assign pair_count = pair_count_q;

endmodule

// File: tb/tb_pair_adder_ctrl.sv
// Directed plus randomized bench for pair_adder_ctrl against a queue-based model.
module tb_pair_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] in_data;
  logic       in_valid, in_ready, flush;
  logic [5:0] out_sum;
  logic       out_valid, out_ready, busy;
  logic [7:0] pair_count;

  int nvec  = 0;
  int nfail = 0;

  // Model: held operand, queue of pending sums, pushed-sum counter.
  bit m_held;
  int m_a;
  int m_q[$];
  int m_pc;

  always #5 clk = ~clk;

  pair_adder_ctrl #(
    .DEPTH (2),
    .CNT_W (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .flush      (flush),
    .out_sum    (out_sum),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .pair_count (pair_count),
    .busy       (busy)
  );

  task automatic expect_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_held = 1'b0;
    m_a    = 0;
    m_q.delete();
    m_pc   = 0;
  endtask

  task automatic check_model();
    expect_eq("out_valid", {31'b0, out_valid}, (m_q.size() != 0) ? 1 : 0);
    expect_eq("out_sum", {26'b0, out_sum}, (m_q.size() != 0) ? m_q[0] : 0);
    expect_eq("in_ready", {31'b0, in_ready}, (!m_held || m_q.size() < 2) ? 1 : 0);
    expect_eq("busy", {31'b0, busy}, (m_held || m_q.size() != 0) ? 1 : 0);
    expect_eq("pair_count", {24'b0, pair_count}, m_pc);
  endtask

  task automatic model_step();
    bit rdy, hs, pop, push;
    int val;
    rdy  = !m_held || (m_q.size() < 2);
    hs   = in_valid && rdy;
    pop  = (m_q.size() != 0) && out_ready;
    push = 1'b0;
    val  = 0;
    if (hs) begin
      if (!m_held) begin
        m_held = 1'b1;
        m_a    = int'(in_data);
      end else begin
        push   = 1'b1;
        val    = m_a + int'(in_data);
        m_held = 1'b0;
      end
    end else if (flush && m_held && m_q.size() < 2) begin
      push   = 1'b1;
      val    = m_a;
      m_held = 1'b0;
    end
    if (pop) void'(m_q.pop_front());
    if (push) begin
      m_q.push_back(val);
      m_pc = (m_pc + 1) % 256;
    end
  endtask

  // Compare current outputs, advance the model, then cross one rising edge.
  task automatic tick();
    check_model();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v);
    in_valid = 1'b1;
    in_data  = 5'(v);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic check_reset_lits(input string tag);
    expect_eq({tag, ".out_valid"}, {31'b0, out_valid}, 0);
    expect_eq({tag, ".out_sum"}, {26'b0, out_sum}, 0);
    expect_eq({tag, ".pair_count"}, {24'b0, pair_count}, 0);
    expect_eq({tag, ".busy"}, {31'b0, busy}, 0);
    expect_eq({tag, ".in_ready"}, {31'b0, in_ready}, 1);
  endtask

  task automatic pulse_reset(input string tag);
    rst = 1'b1;
    #1;
    model_reset();
    check_reset_lits(tag);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    model_reset();
    #1;
    check_reset_lits("por");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic pair, latency and busy release.
    out_ready = 1'b1;
    send(5);
    send(9);
    expect_eq("pair5_9.sum", {26'b0, out_sum}, 14);
    expect_eq("pair5_9.count", {24'b0, pair_count}, 1);
    tick();
    expect_eq("pair5_9.busy", {31'b0, busy}, 0);

    // Extremes.
    send(31);
    send(31);
    expect_eq("max.sum", {26'b0, out_sum}, 62);
    tick();
    send(0);
    send(0);
    expect_eq("zero.sum", {26'b0, out_sum}, 0);
    expect_eq("zero.valid", {31'b0, out_valid}, 1);
    tick();

    // Back-pressure: queue fills, in_ready drops while holding 5.
    out_ready = 1'b0;
    for (int v = 1; v <= 5; v++) send(v);
    expect_eq("bp.in_ready", {31'b0, in_ready}, 0);
    expect_eq("bp.head", {26'b0, out_sum}, 3);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 5'd6;
    tick();
    expect_eq("bp.pop1", {26'b0, out_sum}, 7);
    expect_eq("bp.ready_back", {31'b0, in_ready}, 1);
    tick();
    expect_eq("bp.pop2", {26'b0, out_sum}, 11);
    in_valid = 1'b0;
    tick();

    // Flush closes a half pair; a same-cycle input handshake wins over flush.
    send(17);
    flush = 1'b1;
    tick();
    expect_eq("flush.sum", {26'b0, out_sum}, 17);
    flush = 1'b0;
    tick();
    send(4);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 5'd8;
    tick();
    in_valid = 1'b0;
    expect_eq("flush_vs_pair.sum", {26'b0, out_sum}, 12);
    tick();
    expect_eq("flush_empty.busy", {31'b0, busy}, 0);
    flush = 1'b0;

    // Mid-pair reset with a full queue.
    out_ready = 1'b0;
    send(1); send(2); send(3); send(4); send(12);
    expect_eq("prerst.busy", {31'b0, busy}, 1);
    pulse_reset("midrst");
    out_ready = 1'b1;
    send(1);
    send(1);
    expect_eq("postrst.sum", {26'b0, out_sum}, 2);
    tick();

    // Randomized phases with varying back-pressure.
    for (int blk = 0; blk < 6; blk++) begin
      for (int c = 0; c < 500; c++) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        in_data   = 5'($urandom_range(0, 31));
        flush     = ($urandom_range(0, 7) == 0);
        out_ready = ($urandom_range(0, 5) < blk);
        tick();
      end
    end
    in_valid = 1'b0;
    flush    = 1'b0;

    // Counter wrap after 256 pushes.
    pulse_reset("wraprst");
    out_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      send(i % 32);
      send(1);
      if (i == 254) expect_eq("wrap.255", {24'b0, pair_count}, 255);
    end
    expect_eq("wrap.0", {24'b0, pair_count}, 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
